csa_accumulator: RTL and testbench
==================================

# csa_accumulator

Multi-operand accumulator that sits directly upstream of the 32-bit final adder (`VerilogAdder`). It accepts a stream of operands over a valid/ready handshake and compresses them one per cycle into redundant carry-save form (sum vector S, carry vector C) with a 3:2 compressor. When a group closes, it presents S and C to the final adder's `a` and `b` inputs for carry resolution. Optional per-operand subtraction is supported.

## Interface
- `WIDTH`, 32: operand and vector width. Must match the final adder.
- `MAX_OPS`, 16: maximum operands per group. A group closes automatically when this count is reached.
- `CNT_W`, $clog2(MAX_OPS+1): width of the count output.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  block can accept an operand.
- `in_data`  in  WIDTH  operand X.
- `in_sub`  in  1  subtract X (add ~X + 1) instead of adding it.
- `in_last`  in  1  X is the final operand of its group.
- `out_valid`  out  1  S/C result pair is valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_a`  out  WIDTH  sum vector S. Drives adder `a`.
- `out_b`  out  WIDTH  carry vector C. Drives adder `b`.
- `out_cin`  out  1  adder `Cin`. Constant 0.
- `out_count`  out  CNT_W  number of operands in the presented group.

## Operation
- States: IDLE, ACC, DONE. Encoding is free.
- `in_ready` = 1 in IDLE and ACC, 0 in DONE. `out_valid` = 1 only in DONE.
- Operand accept: `in_valid && in_ready` at a rising edge. Let X' = `in_sub` ? ~`in_data` : `in_data`.
- Accept in IDLE (first operand): S ← X', C ← {0…0, `in_sub`}, count ← 1.
- Accept in ACC: S ← S ^ C ^ X'. C ← (((S&C)|(S&X')|(C&X')) << 1) with bit 0 replaced by `in_sub`. count ← count+1. The shifted-out MSB carry is discarded, so arithmetic is modulo 2^WIDTH.
- After accept: go to DONE if `in_last` or the new count == MAX_OPS. Otherwise go to ACC (from either IDLE or ACC).
- DONE: `out_a`=S, `out_b`=C, `out_count`=count, all held stable. On `out_valid && out_ready`: go to IDLE. S, C and count keep their values until the next accept.
- `in_valid` with `in_ready`=0 is ignored. The operand is not consumed, and upstream must hold it.
- ACC with no `in_valid`: state holds indefinitely. No timeout.
- Invariant: S + C ≡ Σ(±operands) mod 2^WIDTH.
- The adder's `sum` is the group result. Its `Cout` carries no meaning for groups of more than one operand.

## Timing
- Reset (async assert, `rst_n` low): state=IDLE, S=0, C=0, count=0.
  - Reset output values: `out_valid`=0, `out_a`=0, `out_b`=0, `out_count`=0, `out_cin`=0.
  - `in_ready` is 1 only after `rst_n` deasserts. It is forced 0 while `rst_n`=0.
- Reset mid-group or during DONE: the partial or pending result is discarded with no output.
- Latency: if the last operand is accepted at edge N, `out_valid`=1 from edge N onward, i.e. visible in cycle N+1.
- Throughput: a group of k operands occupies k+1 cycles minimum (k accepts + 1 DONE cycle with `out_ready`=1). There is no accept in the same cycle as the output handshake.
- Simultaneous `in_last` and count reaching MAX_OPS: a single close. Identical behaviour to either alone.
- A single-operand group is legal: `out_a`=X', `out_b`={0…,`in_sub`}.
- All outputs are registered or decoded from state only. There is no combinational path from `in_*` to `out_*`.

## Test plan
- Single operand: `in_data`=0x00000005, `in_last`=1 → next cycle `out_valid`=1, `out_a`=0x5, `out_b`=0x0, `out_count`=1. Adder sum=0x5.
- Three-operand add: 1, 2, 3 on consecutive cycles, `in_last` on 3 → `out_a`=0x0, `out_b`=0x6, `out_count`=3. Adder sum=0x6.
- Subtract: 0xA, then 0x3 with `in_sub`=1 and `in_last`=1 → `out_a`=0xFFFFFFF6, `out_b`=0x11. Adder sum=0x7.
- Wrap-around: 0xFFFFFFFF then 0x1 (last) → `out_a`=0xFFFFFFFE, `out_b`=0x2. Adder sum=0x0.
- Backpressure: hold `out_ready`=0 for 3 cycles in DONE with `in_valid`=1 → `in_ready`=0 and outputs unchanged for all 3 cycles, no operand consumed. Raise `out_ready` → IDLE next cycle, then the pending operand is accepted.
- MAX_OPS close and reset: 17 operands of 0x1, `in_last` only on the 17th → first group `out_count`=16, sum 0x10; second group `out_count`=1, sum 0x1. Separately, pull `rst_n` low after 2 accepts → `out_valid`=0, outputs zero, and the next group starts at count 1.

Source files
------------

// File: rtl/csa_accumulator.sv
// ---------------------------------------------------------------------------
// csa_accumulator
//
// Multi-operand accumulator feeding a WIDTH-bit final carry-propagate adder.
// Operands arrive one per cycle over a valid/ready handshake and are folded
// into a redundant carry-save pair (S, C) by a row of 3:2 compressors.
// When a group closes, S and C are presented on out_a/out_b so the
// downstream adder resolves the carries.
//
// The group closes when the operand carries in_last, or when the operand
// count reaches MAX_OPS.
//
// Subtraction is done as ~X + 1. The "+1" is free because the shifted carry
// vector always has an empty bit 0, and in_sub is placed there.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand valid
//   in_ready   out  block can accept an operand (low in DONE and in reset)
//   in_data    in   operand X
//   in_sub     in   subtract X instead of adding it
//   in_last    in   X is the final operand of its group
//   out_valid  out  S/C pair valid (DONE state)
//   out_ready  in   downstream accepts the result
//   out_a      out  sum vector S   -> adder a
//   out_b      out  carry vector C -> adder b
//   out_cin    out  adder carry-in, constant 0
//   out_count  out  number of operands in the presented group
// ---------------------------------------------------------------------------
module csa_accumulator #(
    parameter int WIDTH   = 32,
    parameter int MAX_OPS = 16,
    parameter int CNT_W   = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_cin,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [CNT_W-1:0] count_q, count_d;

    // -----------------------------------------------------------------------
    // Operand conditioning and 3:2 compression, one cell per bit.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] x_cond;      // X' = in_sub ? ~X : X
    logic [WIDTH-1:0] csa_sum;     // S ^ C ^ X'
    logic [WIDTH-1:0] csa_maj;     // majority(S, C, X'), before the shift
    logic [WIDTH-1:0] csa_carry;   // majority shifted up, in_sub in bit 0

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_csa
            assign x_cond[gi]  = in_data[gi] ^ in_sub;
            assign csa_sum[gi] = s_q[gi] ^ c_q[gi] ^ x_cond[gi];
            assign csa_maj[gi] = (s_q[gi] & c_q[gi])
                               | (s_q[gi] & x_cond[gi])
                               | (c_q[gi] & x_cond[gi]);
        end
        // The MSB majority bit falls off the top: arithmetic is mod 2^WIDTH.
        for (gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign csa_carry[gi] = csa_maj[gi-1];
        end
    endgenerate

    assign csa_carry[0] = in_sub;

    // -----------------------------------------------------------------------
    // Handshake decode. in_ready is gated by rst_n so upstream never sees a
    // ready while the block is held in reset.
    // -----------------------------------------------------------------------
    logic             can_accept;
    logic             accept;
    logic             first_op;
    logic [CNT_W-1:0] count_inc;
    logic             close_grp;

    assign can_accept = (state_q != ST_DONE);
    assign accept     = in_valid && can_accept;
    assign first_op   = (state_q == ST_IDLE);
    assign count_inc  = first_op ? CNT_W'(1) : (count_q + CNT_W'(1));
    // Reaching MAX_OPS and in_last together produce one and the same close.
    assign close_grp  = in_last || (count_inc == CNT_W'(MAX_OPS));

    // -----------------------------------------------------------------------
    // Next-state and datapath update.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        count_d = count_q;

        case (state_q)
            ST_IDLE, ST_ACC: begin
                if (accept) begin
                    if (first_op) begin
                        // Start a fresh group: nothing to compress against.
                        s_d = x_cond;
                        c_d = {{(WIDTH-1){1'b0}}, in_sub};
                    end else begin
                        s_d = csa_sum;
                        c_d = csa_carry;
                    end
                    count_d = count_inc;
                    state_d = close_grp ? ST_DONE : ST_ACC;
                end
            end
            ST_DONE: begin
                // S, C and count stay put so the result can be re-read
                // until the next group's first accept overwrites them.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            c_q     <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            count_q <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: registers or state decode only, no path from in_* to out_*.
    // -----------------------------------------------------------------------
    assign in_ready  = rst_n && can_accept;
    assign out_valid = (state_q == ST_DONE);
    assign out_a     = s_q;
    assign out_b     = c_q;
    assign out_cin   = 1'b0;
    assign out_count = count_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// ---------------------------------------------------------------------------
// tb_csa_accumulator
//
// Self-checking bench for csa_accumulator. A reference model tracks each
// group as a plain signed running sum and an operand count; the DUT's
// S + C must equal that sum mod 2^32. Directed cases cover the worked
// examples, backpressure, the MAX_OPS close and mid-group reset, followed
// by randomized groups.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_csa_accumulator;

    localparam int WIDTH   = 32;
    localparam int MAX_OPS = 16;
    localparam int CNT_W   = $clog2(MAX_OPS + 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sub;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic             out_cin;
    logic [CNT_W-1:0] out_count;

    csa_accumulator #(
        .WIDTH  (WIDTH),
        .MAX_OPS(MAX_OPS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sub   (in_sub),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_cin  (out_cin),
        .out_count(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: signed group sum (mod 2^32) and operand count.
    logic [WIDTH-1:0] mdl_sum;
    int               mdl_cnt;
    logic             mdl_closed;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic mdl_clear();
        mdl_sum    = '0;
        mdl_cnt    = 0;
        mdl_closed = 1'b0;
    endtask

    // Present one operand, wait (bounded) for acceptance, update the model
    // and check whether the group closed exactly when the model says so.
    // Entered and left on a falling edge.
    task automatic send_op(input logic [WIDTH-1:0] x, input logic sub,
                           input logic last);
        int guard;
        in_valid = 1'b1;
        in_data  = x;
        in_sub   = sub;
        in_last  = last;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            chk("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            mdl_sum  = sub ? (mdl_sum - x) : (mdl_sum + x);
            mdl_cnt++;
            mdl_closed = last || (mdl_cnt == MAX_OPS);
            chk("close", {31'd0, out_valid}, {31'd0, mdl_closed});
            $display("op   data=%08h sub=%0d last=%0d cnt=%0d out_valid=%0d",
                     x, sub, last, mdl_cnt, out_valid);
        end
    endtask

    // Wait for the result, hold it for `hold` cycles with out_ready low,
    // check it, then hand it off. Optionally check the exact S/C vectors.
    task automatic collect(input int hold, input logic chk_vec,
                           input logic [WIDTH-1:0] exp_a,
                           input logic [WIDTH-1:0] exp_b);
        int               guard;
        logic [WIDTH-1:0] res;
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            @(negedge clk);
        end
        res = out_a + out_b;
        chk("sum", res, mdl_sum);
        chk("count", {{(WIDTH-CNT_W){1'b0}}, out_count}, WIDTH'(mdl_cnt));
        chk("cin", {31'd0, out_cin}, 32'd0);
        if (chk_vec) begin
            chk("out_a", out_a, exp_a);
            chk("out_b", out_b, exp_b);
        end
        $display("grp  a=%08h b=%08h sum=%08h cnt=%0d exp_sum=%08h exp_cnt=%0d",
                 out_a, out_b, res, out_count, mdl_sum, mdl_cnt);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_ready", {31'd0, in_ready}, 32'd1);
        mdl_clear();
    endtask

    initial begin
        logic [WIDTH-1:0] hold_a;
        int               len;
        logic [WIDTH-1:0] x;
        logic             s;

        in_valid  = 1'b0;
        in_data   = '0;
        in_sub    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        mdl_clear();

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_out_b", out_b, 32'd0);
        chk("rst_count", {{(WIDTH-CNT_W){1'b0}}, out_count}, 32'd0);
        chk("rst_cin", {31'd0, out_cin}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // Single operand
        send_op(32'h5, 1'b0, 1'b1);
        collect(0, 1'b1, 32'h5, 32'h0);

        // Three-operand add
        send_op(32'h1, 1'b0, 1'b0);
        send_op(32'h2, 1'b0, 1'b0);
        send_op(32'h3, 1'b0, 1'b1);
        collect(0, 1'b1, 32'h0, 32'h6);

        // Subtract
        send_op(32'hA, 1'b0, 1'b0);
        send_op(32'h3, 1'b1, 1'b1);
        collect(0, 1'b1, 32'hFFFF_FFF6, 32'h11);

        // Wrap-around
        send_op(32'hFFFF_FFFF, 1'b0, 1'b0);
        send_op(32'h1, 1'b0, 1'b1);
        collect(0, 1'b1, 32'hFFFF_FFFE, 32'h2);

        // Single subtract: a = ~X, b = 1
        send_op(32'h1234_5678, 1'b1, 1'b1);
        collect(0, 1'b1, 32'hEDCB_A987, 32'h1);

        // Backpressure with a pending operand held by upstream
        send_op(32'h10, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h7;
        in_sub   = 1'b0;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_a", out_a, 32'h10);
            chk("bp_count", {{(WIDTH-CNT_W){1'b0}}, out_count}, 32'd1);
            @(negedge clk);
        end
        collect(0, 1'b1, 32'h10, 32'h0);
        send_op(32'h7, 1'b0, 1'b1);
        collect(0, 1'b1, 32'h7, 32'h0);

        // MAX_OPS close: 17 ones, in_last only on the 17th
        for (int i = 0; i < 17; i++) begin
            send_op(32'h1, 1'b0, (i == 16));
            if (mdl_closed) collect(0, 1'b0, '0, '0);
        end

        // Reset mid-group discards the partial result
        send_op(32'h21, 1'b0, 1'b0);
        send_op(32'h22, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_out_a", out_a, 32'd0);
        chk("mrst_out_b", out_b, 32'd0);
        chk("mrst_count", {{(WIDTH-CNT_W){1'b0}}, out_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mdl_clear();
        @(negedge clk);
        send_op(32'h9, 1'b0, 1'b1);
        collect(0, 1'b0, '0, '0);

        // Randomized groups, lengths may exceed MAX_OPS
        for (int g = 0; g < 40; g++) begin
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 1)) @(negedge clk);
                x = $urandom;
                s = 1'($urandom_range(0, 1));
                send_op(x, s, (i == len - 1));
                if (mdl_closed) collect($urandom_range(0, 3), 1'b0, '0, '0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
